// File: rtl/xbee_api_rx.sv
`default_nettype none
// ============================================================================
//  Module      : xbee_api_rx
//  Description : XBee API frame receiver. A 16x-oversampled 8N1 UART feeds a
//                frame parser (delimiter, length, API ID, payload, checksum)
//                that streams payload bytes and emits a per-frame verdict.
//                Define XBEE_API_ESCAPE_EN for API mode 2 (0x7D escaping and
//                abort/resync on an unescaped 0x7E).
//  Revision    : 1.0 - initial release
// ============================================================================
module xbee_api_rx #(
    parameter int OVS_DIV = 651,
    parameter int MAX_LEN = 100
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Rx,
    output logic [7:0] Dout,
    output logic       DValid,
    output logic [7:0] FrameType,
    output logic       FrameOk,
    output logic       FrameErr,
    output logic [1:0] ErrCode,
    output logic       Busy
);

    localparam int              TICK_W    = (OVS_DIV > 1) ? $clog2(OVS_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(OVS_DIV - 1);
    localparam logic [15:0]     MAX_LEN_W = 16'(MAX_LEN);

    localparam logic [1:0] ERR_CHKSUM  = 2'b00;
    localparam logic [1:0] ERR_LENGTH  = 2'b01;
    localparam logic [1:0] ERR_FRAMING = 2'b10;

    typedef enum logic [2:0] {
        U_IDLE  = 3'd0,
        U_START = 3'd1,
        U_DATA  = 3'd2,
        U_STOP  = 3'd3,
        U_BREAK = 3'd4
    } uart_state_t;

    typedef enum logic [2:0] {
        P_HUNT    = 3'd0,
        P_LEN_MSB = 3'd1,
        P_LEN_LSB = 3'd2,
        P_API_ID  = 3'd3,
        P_PAYLOAD = 3'd4,
        P_CHKSUM  = 3'd5
    } parse_state_t;

    // ------------------------------------------------------------------
    // Rx synchroniser and oversample tick
    // ------------------------------------------------------------------
    logic              rx_meta;
    logic              rx_sync;
    logic [TICK_W-1:0] tick_cnt;
    logic              tick;

    assign tick = (tick_cnt == TICK_MAX);

    // Two-flop synchroniser; resets to the idle-high line level
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= Rx;
            rx_sync <= rx_meta;
        end
    end

    // Free-running oversample divider, tick on wrap
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)     tick_cnt <= '0;
        else if (tick) tick_cnt <= '0;
        else           tick_cnt <= tick_cnt + 1'b1;
    end

    // ------------------------------------------------------------------
    // UART bit engine
    // ------------------------------------------------------------------
    uart_state_t uart_state, uart_nxt;
    logic [3:0]  os_cnt, os_cnt_nxt;
    logic [2:0]  bit_cnt, bit_cnt_nxt;
    logic [7:0]  shift, shift_nxt;
    logic        byte_stb;
    logic        frm_err;

    // UART state and datapath registers
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            uart_state <= U_IDLE;
            os_cnt     <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
        end else begin
            uart_state <= uart_nxt;
            os_cnt     <= os_cnt_nxt;
            bit_cnt    <= bit_cnt_nxt;
            shift      <= shift_nxt;
        end
    end

    // UART next state: mid-bit sampling 8 ticks into start, then every 16
    always_comb begin
        uart_nxt    = uart_state;
        os_cnt_nxt  = os_cnt;
        bit_cnt_nxt = bit_cnt;
        shift_nxt   = shift;
        byte_stb    = 1'b0;
        frm_err     = 1'b0;
        case (uart_state)
            U_IDLE: begin
                if (!rx_sync) begin
                    uart_nxt   = U_START;
                    os_cnt_nxt = '0;
                end
            end
            U_START: begin
                if (tick) begin
                    if (os_cnt == 4'd7) begin
                        os_cnt_nxt  = '0;
                        bit_cnt_nxt = '0;
                        uart_nxt    = rx_sync ? U_IDLE : U_DATA;
                    end else begin
                        os_cnt_nxt = os_cnt + 4'd1;
                    end
                end
            end
            U_DATA: begin
                if (tick) begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        shift_nxt = {rx_sync, shift[7:1]};
                        if (bit_cnt == 3'd7) uart_nxt = U_STOP;
                        else                 bit_cnt_nxt = bit_cnt + 3'd1;
                    end
                end
            end
            U_STOP: begin
                if (tick) begin
                    os_cnt_nxt = os_cnt + 4'd1;
                    if (os_cnt == 4'd15) begin
                        if (rx_sync) begin
                            byte_stb = 1'b1;
                            uart_nxt = U_IDLE;
                        end else begin
                            frm_err  = 1'b1;
                            uart_nxt = U_BREAK;
                        end
                    end
                end
            end
            U_BREAK: begin
                // A low stop bit may be a break; only re-arm once the line idles
                if (rx_sync) uart_nxt = U_IDLE;
            end
            default: uart_nxt = U_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    parse_state_t p_state, p_nxt;
    logic [15:0]  len, len_nxt;
    logic [15:0]  rem, rem_nxt;
    logic [15:0]  len_full;
    logic [7:0]   sum, sum_nxt;
    logic [7:0]   chk_sum;
    logic [7:0]   data_b;
    logic         take;
    logic [7:0]   dout_nxt, type_nxt;
    logic         dv_nxt, ok_nxt, err_nxt, busy_nxt;
    logic [1:0]   code_nxt;
`ifdef XBEE_API_ESCAPE_EN
    logic         esc, esc_nxt;
`endif

    assign len_full = {len[15:8], data_b};
    assign chk_sum  = sum + data_b;

    // Parser state, accumulators and registered outputs
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            p_state   <= P_HUNT;
            len       <= '0;
            rem       <= '0;
            sum       <= '0;
            Dout      <= '0;
            DValid    <= 1'b0;
            FrameType <= '0;
            FrameOk   <= 1'b0;
            FrameErr  <= 1'b0;
            ErrCode   <= '0;
            Busy      <= 1'b0;
`ifdef XBEE_API_ESCAPE_EN
            esc       <= 1'b0;
`endif
        end else begin
            p_state   <= p_nxt;
            len       <= len_nxt;
            rem       <= rem_nxt;
            sum       <= sum_nxt;
            Dout      <= dout_nxt;
            DValid    <= dv_nxt;
            FrameType <= type_nxt;
            FrameOk   <= ok_nxt;
            FrameErr  <= err_nxt;
            ErrCode   <= code_nxt;
            Busy      <= busy_nxt;
`ifdef XBEE_API_ESCAPE_EN
            esc       <= esc_nxt;
`endif
        end
    end

    // Parser next state; every transition is qualified by a UART event
    always_comb begin
        p_nxt    = p_state;
        len_nxt  = len;
        rem_nxt  = rem;
        sum_nxt  = sum;
        dout_nxt = Dout;
        type_nxt = FrameType;
        code_nxt = ErrCode;
        busy_nxt = Busy;
        dv_nxt   = 1'b0;
        ok_nxt   = 1'b0;
        err_nxt  = 1'b0;
        data_b   = shift;
        take     = byte_stb;
`ifdef XBEE_API_ESCAPE_EN
        esc_nxt  = esc;
        if (byte_stb && (p_state != P_HUNT)) begin
            if (shift == 8'h7E) begin
                // Raw delimiter inside a frame: abort and treat it as a new start
                take     = 1'b0;
                err_nxt  = 1'b1;
                code_nxt = ERR_LENGTH;
                p_nxt    = P_LEN_MSB;
                busy_nxt = 1'b1;
                esc_nxt  = 1'b0;
            end else if (esc) begin
                data_b  = shift ^ 8'h20;
                esc_nxt = 1'b0;
            end else if (shift == 8'h7D) begin
                take    = 1'b0;
                esc_nxt = 1'b1;
            end
        end
        if (frm_err) esc_nxt = 1'b0;
`endif
        if (frm_err) begin
            if (p_state != P_HUNT) begin
                err_nxt  = 1'b1;
                code_nxt = ERR_FRAMING;
                p_nxt    = P_HUNT;
                busy_nxt = 1'b0;
            end
        end else if (take) begin
            case (p_state)
                P_HUNT: begin
                    if (data_b == 8'h7E) begin
                        p_nxt    = P_LEN_MSB;
                        busy_nxt = 1'b1;
                    end
                end
                P_LEN_MSB: begin
                    len_nxt = {data_b, 8'h00};
                    p_nxt   = P_LEN_LSB;
                end
                P_LEN_LSB: begin
                    if ((len_full == 16'd0) || (len_full > MAX_LEN_W)) begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_LENGTH;
                        p_nxt    = P_HUNT;
                        busy_nxt = 1'b0;
                    end else begin
                        len_nxt = len_full;
                        p_nxt   = P_API_ID;
                    end
                end
                P_API_ID: begin
                    type_nxt = data_b;
                    sum_nxt  = data_b;
                    rem_nxt  = len - 16'd1;
                    p_nxt    = (len == 16'd1) ? P_CHKSUM : P_PAYLOAD;
                end
                P_PAYLOAD: begin
                    dout_nxt = data_b;
                    dv_nxt   = 1'b1;
                    sum_nxt  = chk_sum;
                    rem_nxt  = rem - 16'd1;
                    if (rem == 16'd1) p_nxt = P_CHKSUM;
                end
                P_CHKSUM: begin
                    if (chk_sum == 8'hFF) begin
                        ok_nxt = 1'b1;
                    end else begin
                        err_nxt  = 1'b1;
                        code_nxt = ERR_CHKSUM;
                    end
                    p_nxt    = P_HUNT;
                    busy_nxt = 1'b0;
                end
                default: begin
                    p_nxt    = P_HUNT;
                    busy_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
